phase_timer: RTL

PHASE_TIMER -- requirements
Module: phase_timer

---
 rtl/phase_timer_pkg.sv | 38 +++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/phase_timer.sv | 115 +++++++++++
 3 files changed

// File: rtl/phase_timer_pkg.sv
// Shared constants, state type and BCD helpers for phase_timer.
package phase_timer_pkg;

  localparam int unsigned MAX_SEC = 99;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Saturates to MAX_SEC, then splits into tens/ones BCD digits.
  function automatic logic [7:0] sec_to_bcd(input logic [6:0] sec);
    logic [6:0] s;
    s = (sec > 7'(MAX_SEC)) ? 7'(MAX_SEC) : sec;
    return {4'(s / 7'd10), 4'(s % 7'd10)};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] bcd);
    logic [7:0] r;
    if (bcd[3:0] == 4'd0) begin
      r = {bcd[7:4] - 4'd1, 4'd9};
    end else begin
      r = {bcd[7:4], bcd[3:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Single BCD digit to active-low seven-segment pattern; non-digits blank.
module bcd_to_7seg
  import phase_timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/phase_timer.sv
// BCD seconds countdown timer with pause and prescaled tick.
// Define PHASE_TIMER_HEX_EN to drive registered seven-segment outputs.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic       clk50M,
  input  logic       Reset,
  input  logic       load,
  input  logic [6:0] load_sec,
  input  logic       pause,
  output logic       busy,
  output logic       done,
  output logic       tick,
  output logic [7:0] sec_bcd,
  output logic [6:0] HEX_T,
  output logic [6:0] HEX_O
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic          done_q, done_d;
  logic [7:0]    load_bcd;
  logic          tick_int;

  assign load_bcd = sec_to_bcd(load_sec);
  assign tick_int = (state_q == StRun) && !pause && (presc_q == PRESC_MAX);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    // load beats a coincident tick, so no decrement happens on that cycle
    if (load) begin
      presc_d = '0;
      sec_d   = load_bcd;
      if (load_bcd == 8'h00) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        state_d = StRun;
      end
    end else if ((state_q == StRun) && !pause) begin
      if (tick_int) begin
        presc_d = '0;
        sec_d   = bcd_dec(sec_q);
        if (sec_q == 8'h01) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50M or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      presc_q <= '0;
      sec_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = done_q;
  assign tick    = tick_int;
  assign sec_bcd = sec_q;

`ifdef PHASE_TIMER_HEX_EN
  logic [6:0] seg_t, seg_o;
  logic [6:0] hex_t_q, hex_o_q;

  bcd_to_7seg u_seg_t (
    .bcd (sec_q[7:4]),
    .seg (seg_t)
  );

  bcd_to_7seg u_seg_o (
    .bcd (sec_q[3:0]),
    .seg (seg_o)
  );

  always_ff @(posedge clk50M or negedge Reset) begin
    if (!Reset) begin
      hex_t_q <= SEG_BLANK;
      hex_o_q <= SEG_BLANK;
    end else begin
      hex_t_q <= seg_t;
      hex_o_q <= seg_o;
    end
  end

  assign HEX_T = hex_t_q;
  assign HEX_O = hex_o_q;
`else
  assign HEX_T = SEG_BLANK;
  assign HEX_O = SEG_BLANK;
`endif

endmodule
